// File: rtl/serial_tx_packetizer.sv
// Packet FIFO feeding a UART-style serializer: start bit, LSB-first data,
// stop bit per word, with optional XOR checksum word per packet.
module serial_tx_packetizer #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned QAW    = 3,
  parameter int unsigned DIV_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*WORD_W-1:0] in_data,
  input  logic                    msb_word_first,
  input  logic                    checksum_en,
  input  logic [DIV_W-1:0]        baud_div,
  output logic                    tx,
  output logic                    busy,
  output logic                    pkt_done,
  output logic [QAW:0]            level
);

  localparam int unsigned PW    = WORDS * WORD_W;
  localparam int unsigned DEPTH = 1 << QAW;
  localparam int unsigned BCW   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned WCW   = $clog2(WORDS + 1);
  localparam logic [QAW:0] FULL = (QAW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      mem [DEPTH];
  logic [QAW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QAW:0]       level_q, level_d;
  logic [PW-1:0]      pkt_q, pkt_d;
  logic               msb_q, msb_d, cks_q, cks_d;
  logic [DIV_W-1:0]   div_q, div_d, baud_cnt_q, baud_cnt_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]     word_cnt_q, word_cnt_d, last_word, last_word_d;
  logic [WORD_W-1:0]  sh_q, sh_d;
  logic               tx_q, tx_d, busy_q, busy_d, done_q, done_d, rdy_q, rdy_d;
  logic               push, pop;

  // Word at transmit position k: data words in the chosen order, then the checksum.
  function automatic logic [WORD_W-1:0] sel_word(input logic [PW-1:0] pkt,
                                                 input logic msb,
                                                 input logic [WCW-1:0] k);
    logic [WORD_W-1:0] w;
    int unsigned       kk;
    int unsigned       idx;
    w  = '0;
    kk = 32'(k);
    if (kk >= WORDS) begin
      for (int unsigned i = 0; i < WORDS; i++) w ^= pkt[i*WORD_W +: WORD_W];
    end else begin
      idx = msb ? (WORDS - 1 - kk) : kk;
      w   = pkt[idx*WORD_W +: WORD_W];
    end
    return w;
  endfunction

  // Next-state, FIFO bookkeeping and registered-output precompute.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    pkt_d      = pkt_q;
    msb_d      = msb_q;
    cks_d      = cks_q;
    div_d      = div_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    sh_d       = sh_q;
    push       = in_valid && (level_q != FULL);
    pop        = (state_q == S_LOAD);
    last_word  = cks_q ? WCW'(WORDS) : WCW'(WORDS - 1);

    case (state_q)
      S_IDLE: if (level_q != '0) state_d = S_LOAD;
      S_LOAD: begin
        pkt_d      = mem[rd_ptr_q];
        msb_d      = msb_word_first;
        cks_d      = checksum_en;
        div_d      = baud_div;
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        sh_d       = sel_word(mem[rd_ptr_q], msb_word_first, '0);
        state_d    = S_START;
      end
      S_START: begin
        if (baud_cnt_q == div_q) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_cnt_q == div_q) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == BCW'(WORD_W - 1)) begin
            state_d = S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            sh_d      = sh_q >> 1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_cnt_q == div_q) begin
          baud_cnt_d = '0;
          if (word_cnt_q == last_word) begin
            state_d = (level_q != '0) ? S_LOAD : S_IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
            sh_d       = sel_word(pkt_q, msb_q, word_cnt_q + 1'b1);
            state_d    = S_START;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;

    tx_d = 1'b1;
    if (state_d == S_START)     tx_d = 1'b0;
    else if (state_d == S_DATA) tx_d = sh_d[0];

    last_word_d = cks_d ? WCW'(WORDS) : WCW'(WORDS - 1);
    done_d = (state_d == S_STOP) && (baud_cnt_d == div_d) && (word_cnt_d == last_word_d);
    rdy_d  = (level_d != FULL);
    busy_d = (level_d != '0) || (state_d != S_IDLE);
  end

  // State, counters, latched packet and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_q      <= '0;
      msb_q      <= 1'b0;
      cks_q      <= 1'b0;
      div_q      <= '0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      sh_q       <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_q      <= pkt_d;
      msb_q      <= msb_d;
      cks_q      <= cks_d;
      div_q      <= div_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rdy_q      <= rdy_d;
    end
  end

  // Packet storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign pkt_done = done_q;
  assign in_ready = rdy_q;
  assign level    = level_q;

endmodule

// File: tb/tb_serial_tx_packetizer.sv
// Bench for serial_tx_packetizer: per-cycle comparison against a waveform-queue
// model of the line, plus literal checks of decoded packets and timing.
module tb_serial_tx_packetizer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        msb_word_first = 1'b0;
  logic        checksum_en = 1'b0;
  logic [7:0]  baud_div = 8'd3;
  logic        tx, busy, pkt_done;
  logic [3:0]  level;

  serial_tx_packetizer #(.WORDS(4), .WORD_W(8), .QAW(3), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .msb_word_first(msb_word_first), .checksum_en(checksum_en),
    .baud_div(baud_div), .tx(tx), .busy(busy), .pkt_done(pkt_done), .level(level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // One clock of line activity: act = serializer busy, load = the fetch cycle.
  typedef struct packed { logic act; logic tx; logic done; logic load; } item_t;
  localparam item_t IDLE_IT = item_t'(4'b0100);
  localparam item_t LOAD_IT = item_t'(4'b1101);

  item_t       tmpw[$];
  item_t       wave[$];
  logic [31:0] q[$];
  item_t       cur = item_t'(4'b0100);
  int          m_lvl;
  logic        m_push;
  logic        tr_tx   [0:299];
  logic        tr_done [0:299];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Whole line waveform of one packet, one entry per clock.
  function automatic void build(input logic [31:0] pkt, input logic msb, input logic cks, input int d);
    logic [7:0] w [5];
    int nw;
    item_t it;
    tmpw.delete();
    nw = cks ? 5 : 4;
    w[4] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      w[k] = msb ? pkt[(3-k)*8 +: 8] : pkt[k*8 +: 8];
      w[4] ^= pkt[k*8 +: 8];
    end
    for (int k = 0; k < nw; k++)
      for (int s = 0; s < 10; s++)
        for (int c = 0; c <= d; c++) begin
          it = item_t'(4'b1000);
          it.tx = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : w[k][s-1];
          it.done = (k == nw-1) && (s == 9) && (c == d);
          tmpw.push_back(it);
        end
  endfunction

  // Reference model: FIFO as a queue, line as a queue of future clocks.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      wave.delete();
      cur = IDLE_IT;
    end else begin
      m_lvl  = q.size();
      m_push = in_valid && (m_lvl != DEPTH);
      if (cur.load) begin
        build(q.pop_front(), msb_word_first, checksum_en, int'(baud_div));
        wave = tmpw;
        cur = wave.pop_front();
      end else if (wave.size() != 0) cur = wave.pop_front();
      else if (m_lvl != 0) cur = LOAD_IT;
      else cur = IDLE_IT;
      if (m_push) q.push_back(in_data);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("tx", 32'(tx), 32'(cur.tx));
    chk("pkt_done", 32'(pkt_done), 32'(cur.done));
    chk("level", 32'(level), 32'(q.size()));
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("busy", 32'(busy), 32'((q.size() != 0) || cur.act));
  end

  task automatic send(input logic [31:0] p);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = p;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_tx_low();
    int t;
    t = 0;
    while (tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    chk("start_timeout", 32'(t < 100), 32'd1);
  endtask

  task automatic capture(input int n);
    wait_tx_low();
    for (int i = 0; i < n; i++) begin
      tr_tx[i] = tx;
      tr_done[i] = pkt_done;
      @(negedge clk);
    end
  endtask

  // Decode bytes (4-clock bits) from the trace and check done position.
  task automatic chk_trace(input int nb, input logic [39:0] exp_bytes, input int n, input int done_at);
    logic [7:0] b;
    logic [39:0] e;
    int cnt, idx;
    e = exp_bytes;
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < 8; i++) b[i] = tr_tx[k*40 + 4*(i+1) + 2];
      chk($sformatf("byte%0d", k), 32'(b), 32'(e[k*8 +: 8]));
    end
    cnt = 0; idx = -1;
    for (int i = 0; i < n; i++) if (tr_done[i]) begin cnt++; if (idx < 0) idx = i; end
    chk("done_count", 32'(cnt), 32'd1);
    chk("done_index", 32'(idx), 32'(done_at));
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < budget) begin @(negedge clk); t++; end
    chk("drain_timeout", 32'(t < budget), 32'd1);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);

    // Pin the model against hand-computed waveforms.
    build(32'h44332211, 1'b1, 1'b0, 3);
    chk("model_len_a", 32'(tmpw.size()), 32'd160);
    chk("model_done_a", 32'(tmpw[159].done), 32'd1);
    chk("model_start_a", 32'(tmpw[0].tx), 32'd0);
    chk("model_b1_a", 32'(tmpw[8].tx), 32'd0);
    chk("model_b2_a", 32'(tmpw[12].tx), 32'd1);
    build(32'h44332211, 1'b0, 1'b1, 3);
    chk("model_len_b", 32'(tmpw.size()), 32'd200);
    chk("model_w0b0_b", 32'(tmpw[4].tx), 32'd1);
    chk("model_ckb0_b", 32'(tmpw[164].tx), 32'd0);
    chk("model_ckb2_b", 32'(tmpw[172].tx), 32'd1);

    @(negedge clk);
    rst = 1'b0;

    // MSB word first, no checksum.
    msb_word_first = 1'b1; checksum_en = 1'b0; baud_div = 8'd3;
    send(32'h44332211);
    capture(170);
    chk_trace(4, 40'h00_11_22_33_44, 170, 159);
    wait_idle(100);

    // LSB word first with checksum.
    msb_word_first = 1'b0; checksum_en = 1'b1;
    send(32'h44332211);
    capture(210);
    chk_trace(5, 40'h44_44_33_22_11, 210, 199);
    wait_idle(100);

    // Fill the FIFO behind a slow packet; later packets run at 1 clock/bit.
    baud_div = 8'd255;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom();
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_level", 32'(level), 32'd8);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    baud_div = 8'd0;
    wait_idle(15000);

    // Reset in the middle of a data bit of word 2, with a packet queued.
    baud_div = 8'd3; msb_word_first = 1'b0; checksum_en = 1'b0;
    send(32'hA5C3_0F96);
    send(32'h1234_5678);
    wait_tx_low();
    repeat (89) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    msb_word_first = 1'b1;
    send(32'hDEAD_BEEF);
    wait_idle(300);

    // Divisor change mid-packet applies only to the next packet.
    msb_word_first = 1'b0; checksum_en = 1'b0; baud_div = 8'd3;
    send(32'h0102_0304);
    send(32'h8070_6050);
    wait_tx_low();
    repeat (60) @(negedge clk);
    baud_div = 8'd7;
    t = 0;
    while (pkt_done !== 1'b1 && t < 400) begin @(negedge clk); t++; end
    chk("first_done_timeout", 32'(t < 400), 32'd1);
    t = 0;
    @(negedge clk); t++;
    while (pkt_done !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    chk("second_pkt_span", 32'(t), 32'd321);
    wait_idle(100);

    // Random traffic with configuration churn.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid       = ($urandom_range(0, 19) == 0);
      in_data        = $urandom();
      msb_word_first = 1'($urandom_range(0, 1));
      checksum_en    = 1'($urandom_range(0, 1));
      baud_div       = 8'($urandom_range(0, 2));
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle(15000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_tx_packetizer.md
SERIAL_TX_PACKETIZER -- requirements
Module: serial_tx_packetizer

Interface
REQ-001 SHALL have parameter WORDS, default 4, meaning words per packet (>=2).
REQ-002 SHALL have parameter WORD_W, default 8, meaning bits per serial word.
REQ-003 SHALL have parameter QAW, default 3, meaning FIFO address width (depth 2**QAW packets).
REQ-004 SHALL have parameter DIV_W, default 8, meaning bit-period divisor width.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  packet offered.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a packet.
REQ-009 SHALL have port in_data  input  WORDS*WORD_W  packet; word k = bits [k*WORD_W +: WORD_W].
REQ-010 SHALL have port msb_word_first  input  1  1: send word WORDS-1 first; 0: word 0 first.
REQ-011 SHALL have port checksum_en  input  1  append XOR checksum word.
REQ-012 SHALL have port baud_div  input  DIV_W  bit period = baud_div+1 clocks.
REQ-013 SHALL have port tx  output  1  serial line, idle high.
REQ-014 SHALL have port busy  output  1  FIFO non-empty or serializer active.
REQ-015 SHALL have port pkt_done  output  1  one-cycle pulse at end of packet.
REQ-016 SHALL have port level  output  QAW+1  packets stored in FIFO.

Function
REQ-017 SHALL be fully synchronous to clk rising edge; no logic clocked by internal signals.
REQ-018 SHALL accept a packet on a clk edge where in_valid & in_ready; in_ready = (level != 2**QAW).
REQ-019 SHALL ignore in_valid while in_ready=0; with FIFO full, a same-cycle pop does not enable a push.
REQ-020 SHALL pop the FIFO head in LOAD and latch it with msb_word_first, checksum_en and baud_div; these inputs SHALL NOT affect a packet already loaded.
REQ-021 SHALL implement FSM IDLE -> LOAD -> START -> DATA -> STOP -> (next word: START | packet end: IDLE or LOAD).
REQ-022 SHALL leave IDLE for LOAD on the edge after level becomes non-zero; tx falls (START) on the second rising edge after the accepting edge when idle and empty.
REQ-023 SHALL drive per word: one start bit (0), WORD_W data bits LSB first, one stop bit (1), each bit exactly baud_div+1 clocks.
REQ-024 SHALL send WORDS words in order set by the latched msb_word_first, then, if latched checksum_en, one extra word = XOR of all WORDS words.
REQ-025 SHALL pulse pkt_done for one cycle on the last clock of the final stop bit of each packet.
REQ-026 SHALL go from final STOP directly to LOAD when FIFO non-empty, giving no idle gap between packets.
REQ-027 SHALL keep tx=1 in IDLE and LOAD; baud_div=0 gives 1-clock bits.
REQ-028 SHALL update level by +1 on push only, -1 on pop only, unchanged on simultaneous push and pop; pointers wrap modulo 2**QAW.

Reset
REQ-029 SHALL on rst asynchronously force tx=1, in_ready=1, busy=0, pkt_done=0, level=0, FSM=IDLE, pointers and counters=0.
REQ-030 SHALL discard FIFO contents and any partly sent word on reset mid-operation; no pkt_done for the aborted packet.
REQ-031 SHALL resume normal acceptance on the first clock edge after rst deasserts.

Verification (WORDS=4, WORD_W=8, QAW=3, baud_div=3)
REQ-032 SHALL verify reset: assert rst -> tx=1, in_ready=1, busy=0, level=0, pkt_done=0.
REQ-033 SHALL verify 0x44332211, msb_word_first=1, checksum_en=0 -> bytes 44,33,22,11, each 40 clocks, pkt_done once 160 clocks after start bit.
REQ-034 SHALL verify 0x44332211, msb_word_first=0, checksum_en=1 -> bytes 11,22,33,44,44, 200 clocks, one pkt_done.
REQ-035 SHALL verify back-to-back in_valid for 12 packets, serializer stalled by baud_div=255 -> level reaches 8, in_ready=0, excess offers dropped, accepted packets sent in order with no inter-packet gap.
REQ-036 SHALL verify rst asserted mid-data-bit of word 2 -> tx=1 same cycle, level=0, next packet transmits cleanly.
REQ-037 SHALL verify baud_div changed 3->7 mid-packet -> current packet stays 4 clocks/bit; next packet uses 8.
